// File: rtl/arbitro_vc.sv
// arbitro_vc: weighted-priority drain of VC0/VC1 into D0/D1.
// VC0 preferred; VC1 gets a slot after PESO_VC0 straight VC0 grants.
module arbitro_vc #(
  parameter int BITBUS   = 6,
  parameter int PESO_VC0 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [BITBUS-1:0] vc0_data,
  input  logic [BITBUS-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [BITBUS-1:0] data_out,
  output logic [1:0]        state,
  output logic [2:0]        peso_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } st_t;

  localparam logic [2:0] PESO = 3'(PESO_VC0);

  st_t              st_q;
  logic             stall;
  logic             req0;
  logic             req1;
  logic             grant0;
  logic             grant1;
  logic [BITBUS-1:0] word;

  assign stall = d0_almost_full | d1_almost_full;
  assign req0  = ~vc0_empty;
  assign req1  = ~vc1_empty;

  // Pick at most one VC per cycle; VC1 wins once the weight is used up.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && enable && !stall) begin
      priority case (1'b1)
        req1 && (peso_cnt == PESO || !req0): grant1 = 1'b1;
        req0:                                grant0 = 1'b1;
        default: ;
      endcase
    end
  end

  assign vc0_pop = grant0;
  assign vc1_pop = grant1;
  assign word    = grant1 ? vc1_data : vc0_data;
  assign state   = st_q;

  // Capture the popped word, steer it, track state and VC0 weight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      data_out <= '0;
      st_q     <= IDLE;
      peso_cnt <= 3'd0;
    end else begin
      d0_push <= 1'b0;
      d1_push <= 1'b0;
      if (grant0 || grant1) begin
        data_out <= word;
        d0_push  <= ~word[BITBUS-1];
        d1_push  <= word[BITBUS-1];
        st_q     <= SERVE;
      end else if (enable && stall && (req0 || req1)) begin
        st_q <= STALL;
      end else begin
        st_q <= IDLE;
      end
      if (grant1) begin
        peso_cnt <= 3'd0;
      end else if (grant0 && peso_cnt != PESO) begin
        peso_cnt <= peso_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_vc.sv
// tb_arbitro_vc: directed vector table plus reset corner sequences.
// Pops checked mid-cycle, registered outputs checked after the edge.
module tb_arbitro_vc;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       vc0_empty;
  logic       vc1_empty;
  logic [5:0] vc0_data;
  logic [5:0] vc1_data;
  logic       d0_almost_full;
  logic       d1_almost_full;
  logic       vc0_pop;
  logic       vc1_pop;
  logic       d0_push;
  logic       d1_push;
  logic [5:0] data_out;
  logic [1:0] state;
  logic [2:0] peso_cnt;

  int checks   = 0;
  int failures = 0;

  arbitro_vc #(.BITBUS(6), .PESO_VC0(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .data_out       (data_out),
    .state          (state),
    .peso_cnt       (peso_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       e0;
    logic       e1;
    logic [5:0] v0;
    logic [5:0] v1;
    logic       af0;
    logic       af1;
    logic       p0;
    logic       p1;
    logic       dp0;
    logic       dp1;
    logic [5:0] dout;
    logic [1:0] st;
    logic [2:0] cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic en, input logic e0, input logic e1,
    input logic [5:0] v0, input logic [5:0] v1,
    input logic af0, input logic af1,
    input logic p0, input logic p1,
    input logic dp0, input logic dp1,
    input logic [5:0] dout, input logic [1:0] st,
    input logic [2:0] cnt);
    vec_t v;
    v.en = en; v.e0 = e0; v.e1 = e1;
    v.v0 = v0; v.v1 = v1;
    v.af0 = af0; v.af1 = af1;
    v.p0 = p0; v.p1 = p1;
    v.dp0 = dp0; v.dp1 = dp1;
    v.dout = dout; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enable         = v.en;
    vc0_empty      = v.e0;
    vc1_empty      = v.e1;
    vc0_data       = v.v0;
    vc1_data       = v.v1;
    d0_almost_full = v.af0;
    d1_almost_full = v.af1;
  endtask

  initial begin
    logic pdp0;
    logic pdp1;

    // fields: en e0 e1 v0 v1 af0 af1 | p0 p1 | dp0 dp1 dout st cnt
    // routing after reset
    vt.push_back(mk(1,0,1,6'h05,6'h00,0,0, 1,0, 1,0,6'h05,1,1));
    vt.push_back(mk(1,0,1,6'h25,6'h00,0,0, 1,0, 0,1,6'h25,1,2));
    vt.push_back(mk(1,1,1,6'h00,6'h00,0,0, 0,0, 0,0,6'h25,0,2));
    // VC1 alone clears the weight
    vt.push_back(mk(1,1,0,6'h00,6'h3A,0,0, 0,1, 0,1,6'h3A,1,0));
    // weighting, both busy
    vt.push_back(mk(1,0,0,6'h01,6'h21,0,0, 1,0, 1,0,6'h01,1,1));
    vt.push_back(mk(1,0,0,6'h22,6'h23,0,0, 1,0, 0,1,6'h22,1,2));
    vt.push_back(mk(1,0,0,6'h03,6'h24,0,0, 1,0, 1,0,6'h03,1,3));
    vt.push_back(mk(1,0,0,6'h04,6'h05,0,0, 0,1, 1,0,6'h05,1,0));
    vt.push_back(mk(1,0,0,6'h06,6'h26,0,0, 1,0, 1,0,6'h06,1,1));
    vt.push_back(mk(1,0,0,6'h07,6'h27,0,0, 1,0, 1,0,6'h07,1,2));
    vt.push_back(mk(1,0,0,6'h28,6'h29,0,0, 1,0, 0,1,6'h28,1,3));
    vt.push_back(mk(1,0,0,6'h09,6'h2A,0,0, 0,1, 0,1,6'h2A,1,0));
    // backpressure
    vt.push_back(mk(1,0,1,6'h0B,6'h00,0,0, 1,0, 1,0,6'h0B,1,1));
    vt.push_back(mk(1,0,1,6'h2C,6'h00,0,1, 0,0, 0,0,6'h0B,2,1));
    vt.push_back(mk(1,0,1,6'h2C,6'h00,0,1, 0,0, 0,0,6'h0B,2,1));
    vt.push_back(mk(1,0,1,6'h2C,6'h00,0,0, 1,0, 0,1,6'h2C,1,2));
    // enable low holds the count
    vt.push_back(mk(0,0,0,6'h0D,6'h2E,0,0, 0,0, 0,0,6'h2C,0,2));
    vt.push_back(mk(0,0,0,6'h0D,6'h2E,0,0, 0,0, 0,0,6'h2C,0,2));
    vt.push_back(mk(1,0,0,6'h0D,6'h2E,0,0, 1,0, 1,0,6'h0D,1,3));
    vt.push_back(mk(1,0,0,6'h0D,6'h2E,0,0, 0,1, 0,1,6'h2E,1,0));
    // saturation with VC1 empty
    vt.push_back(mk(1,0,1,6'h10,6'h00,0,0, 1,0, 1,0,6'h10,1,1));
    vt.push_back(mk(1,0,1,6'h11,6'h00,0,0, 1,0, 1,0,6'h11,1,2));
    vt.push_back(mk(1,0,1,6'h12,6'h00,0,0, 1,0, 1,0,6'h12,1,3));
    vt.push_back(mk(1,0,1,6'h13,6'h00,0,0, 1,0, 1,0,6'h13,1,3));
    vt.push_back(mk(1,0,0,6'h14,6'h31,0,0, 0,1, 0,1,6'h31,1,0));
    // stall with nothing queued, stall with enable low
    vt.push_back(mk(1,1,1,6'h00,6'h00,1,0, 0,0, 0,0,6'h31,0,0));
    vt.push_back(mk(0,0,1,6'h15,6'h00,1,0, 0,0, 0,0,6'h31,0,0));

    // reset held with work pending
    reset = 1'b0;
    drive(mk(1,0,1,6'h05,6'h00,0,0, 0,0, 0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pop0", 0, vc0_pop, 0);
    chk("rst_pop1", 0, vc1_pop, 0);
    chk("rst_push", 0, {d0_push, d1_push}, 0);
    chk("rst_dout", 0, data_out, 0);
    chk("rst_st", 0, state, 0);
    chk("rst_cnt", 0, peso_cnt, 0);
    reset = 1'b1;

    pdp0 = 1'b0;
    pdp1 = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vt[i]);
      #1;
      chk("pop0", i, vc0_pop, vt[i].p0);
      chk("pop1", i, vc1_pop, vt[i].p1);
      chk("held_push", i, {d0_push, d1_push}, {pdp0, pdp1});
      @(posedge clk);
      #1;
      chk("d0_push", i, d0_push, vt[i].dp0);
      chk("d1_push", i, d1_push, vt[i].dp1);
      chk("data_out", i, data_out, vt[i].dout);
      chk("state", i, state, vt[i].st);
      chk("peso_cnt", i, peso_cnt, vt[i].cnt);
      pdp0 = vt[i].dp0;
      pdp1 = vt[i].dp1;
    end

    // asynchronous reset while a D1 push is in flight
    @(negedge clk);
    drive(mk(1,0,1,6'h25,6'h00,0,0, 0,0, 0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("ar_pre_push", 0, d1_push, 1);
    chk("ar_pre_cnt", 0, peso_cnt, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_d1_push", 0, d1_push, 0);
    chk("ar_dout", 0, data_out, 0);
    chk("ar_cnt", 0, peso_cnt, 0);
    chk("ar_st", 0, state, 0);
    chk("ar_pop0", 0, vc0_pop, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_resume", 0, vc0_pop, 1);
    @(posedge clk);
    #1;
    chk("ar_resume_push", 0, d1_push, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbitro_vc.md
Name: arbitro_vc

Overview:
Weighted-priority scheduler that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the switch datapath. It is gated by the active_out indication of the control state machine. Each popped word is steered by its destination bit and pushed one cycle later. VC0 is the high-priority channel; a weight counter guarantees VC1 a slot after PESO_VC0 consecutive VC0 grants. Pops stop while either destination FIFO is almost full.

Parameters:
BITBUS, 6, data word width; bit [BITBUS-1] is the destination select (0 = D0, 1 = D1).
PESO_VC0, 3, maximum consecutive VC0 grants while VC1 is non-empty (must be 1..7).

Ports:
clk  input  1  system clock, all registers on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  drain permission (driven by active_out of the control FSM)
vc0_empty  input  1  VC0 FIFO empty flag
vc1_empty  input  1  VC1 FIFO empty flag
vc0_data  input  BITBUS  VC0 head word (show-ahead, valid while !vc0_empty)
vc1_data  input  BITBUS  VC1 head word (show-ahead, valid while !vc1_empty)
d0_almost_full  input  1  D0 almost-full flag
d1_almost_full  input  1  D1 almost-full flag
vc0_pop  output  1  combinational pop strobe to VC0
vc1_pop  output  1  combinational pop strobe to VC1
d0_push  output  1  registered push strobe to D0
d1_push  output  1  registered push strobe to D1
data_out  output  BITBUS  registered word for D0/D1
state  output  2  registered scheduler state: 0 IDLE, 1 SERVE, 2 STALL
peso_cnt  output  3  registered consecutive-VC0-grant counter

Behaviour:
- Reset (reset=0, asynchronous, immediate): d0_push=d1_push=0, data_out=0, state=IDLE, peso_cnt=0. vc0_pop and vc1_pop are forced to 0 while reset=0. A push in flight at reset assertion is dropped.
- Definitions per cycle: stall = d0_almost_full | d1_almost_full; req0 = !vc0_empty; req1 = !vc1_empty.
- Grant (combinational, at most one pop per cycle), evaluated only when enable=1 and stall=0:
  - if req1 and (peso_cnt == PESO_VC0 or !req0): grant VC1.
  - else if req0: grant VC0.
  - else: no grant.
- Pop: vcX_pop = 1 in the grant cycle. Pops are never asserted while the corresponding FIFO is empty, while enable=0, or while stall=1.
- Counter update (registered):
  - VC0 grant: peso_cnt += 1, saturating at PESO_VC0.
  - VC1 grant: peso_cnt = 0.
  - No grant: peso_cnt holds.
  - VC0 granted while VC1 is empty: counter still increments (saturates), so VC1 is served first once it becomes non-empty after PESO_VC0 or more VC0 grants.
- Push (registered, latency 1):
  - On a grant in cycle N, the granted head word is captured into data_out at the edge ending cycle N.
  - In cycle N+1, d0_push=1 if data_out[BITBUS-1]=0, d1_push=1 otherwise.
  - Without a grant, both push strobes are 0 next cycle; data_out holds its last value.
  - d0_push and d1_push are never simultaneously 1.
- In-flight word: a word popped in cycle N is always pushed in N+1, even if stall rises or enable falls in N+1. The almost-full thresholds budget this one word of slack.
- State register (next value from the current cycle's decision):
  - SERVE if a grant occurred.
  - STALL if enable=1, stall=1, and (req0|req1).
  - IDLE otherwise (enable=0, or both VCs empty).
  - Invariant: state==SERVE exactly when d0_push|d1_push.
- Back-to-back: full throughput of one word per cycle while enable=1, stall=0, and a VC is non-empty.
- enable falling mid-burst: pops stop in the same cycle; peso_cnt is retained and arbitration resumes with it.

Test Plan:
- Reset: hold reset=0 with VC0 non-empty and enable=1 -> pops, pushes, and data_out are 0, state=0; release reset -> vc0_pop=1 in the first cycle, d0/d1 push in the next.
- Routing: VC0 words 6'h05, 6'h25 with VC1 empty -> cycle+1: d0_push with data_out=6'h05; cycle+2: d1_push with data_out=6'h25; state=1 on both push cycles.
- Weighting: both VCs hold 8 words, PESO_VC0=3 -> pop order VC0,VC0,VC0,VC1,VC0,VC0,VC0,VC1; peso_cnt sequence 1,2,3,0,1,2,3,0.
- Backpressure: d1_almost_full=1 during a VC0 burst -> pops stop that cycle; the popped word is still pushed next cycle; state=2; deassert -> pops resume the following cycle.
- Enable: enable=0 with both VCs non-empty -> no pops, state=0, peso_cnt held; re-enable -> arbitration continues from the held count.
- Asynchronous reset mid-push: assert reset=0 between edges while d1_push=1 -> d1_push, data_out, and peso_cnt clear immediately, without waiting for clk.
